vga_timing_gen: RTL

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_pkg.sv | 24 ++
 rtl/vga_sync_counter.sv | 45 ++++
 rtl/vga_timing_gen.sv | 137 +++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared VGA timing constants: 640x480 @ 60 Hz defaults, derived totals,
// and the coordinate width used for DrawX/DrawY and the internal counters.
package vga_pkg;

  localparam int COORD_W = 10;
  localparam int FCNT_W  = 16;

  localparam int H_VISIBLE_DEF = 640;
  localparam int H_FP_DEF      = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BP_DEF      = 48;

  localparam int V_VISIBLE_DEF = 480;
  localparam int V_FP_DEF      = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BP_DEF      = 33;

  localparam int H_TOTAL_DEF = H_VISIBLE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int V_TOTAL_DEF = V_VISIBLE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [FCNT_W-1:0]  fcnt_t;

endpackage

// File: rtl/vga_sync_counter.sv
// One timing axis: a wrapping counter with sync-pulse and visible-region
// decode of its current value. Used once per line and once per frame.
module vga_sync_counter #(
  parameter int TOTAL      = 800,
  parameter int SYNC_START = 656,
  parameter int SYNC_W     = 96,
  parameter int VISIBLE    = 640,
  parameter int CNT_W      = 10
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  output logic [CNT_W-1:0] count_o,
  output logic             wrap_o,
  output logic             sync_n_o,
  output logic             visible_o
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] SS   = CNT_W'(SYNC_START);
  localparam logic [CNT_W-1:0] SE   = CNT_W'(SYNC_START + SYNC_W);
  localparam logic [CNT_W-1:0] VIS  = CNT_W'(VISIBLE);

  logic [CNT_W-1:0] count_q, count_d;

  // Next count: step when enabled, wrapping from the last value back to 0.
  always_comb begin
    count_d = count_q;
    if (en_i) begin
      count_d = (count_q == LAST) ? '0 : count_q + CNT_W'(1);
    end
  end

  // Counter register with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) count_q <= '0;
    else         count_q <= count_d;
  end

  assign count_o   = count_q;
  assign wrap_o    = en_i && (count_q == LAST);
  assign sync_n_o  = !((count_q >= SS) && (count_q < SE));
  assign visible_o = (count_q < VIS);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator. Horizontal and vertical counters advance on
// pix_en; every output is a registered decode of the pre-increment position,
// so DrawX/DrawY and the sync/blank flags always describe the same pixel.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_VISIBLE = H_VISIBLE_DEF,
  parameter int H_FP      = H_FP_DEF,
  parameter int H_SYNC    = H_SYNC_DEF,
  parameter int H_BP      = H_BP_DEF,
  parameter int V_VISIBLE = V_VISIBLE_DEF,
  parameter int V_FP      = V_FP_DEF,
  parameter int V_SYNC    = V_SYNC_DEF,
  parameter int V_BP      = V_BP_DEF
) (
  input  logic               vga_clk,
  input  logic               reset_n,
  input  logic               pix_en,
  output logic               hs,
  output logic               vs,
  output logic               blank,
  output logic [COORD_W-1:0] DrawX,
  output logic [COORD_W-1:0] DrawY,
  output logic               line_start,
  output logic               frame_start,
  output logic [FCNT_W-1:0]  frame_count
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  coord_t hc, vc;
  logic   h_wrap, v_wrap;
  logic   h_sync_n, v_sync_n;
  logic   h_vis, v_vis;

  vga_sync_counter #(
    .TOTAL      (H_TOTAL),
    .SYNC_START (H_VISIBLE + H_FP),
    .SYNC_W     (H_SYNC),
    .VISIBLE    (H_VISIBLE),
    .CNT_W      (COORD_W)
  ) u_hcnt (
    .clk_i     (vga_clk),
    .rst_ni    (reset_n),
    .en_i      (pix_en),
    .count_o   (hc),
    .wrap_o    (h_wrap),
    .sync_n_o  (h_sync_n),
    .visible_o (h_vis)
  );

  // The vertical axis steps once per line: h_wrap already includes pix_en.
  vga_sync_counter #(
    .TOTAL      (V_TOTAL),
    .SYNC_START (V_VISIBLE + V_FP),
    .SYNC_W     (V_SYNC),
    .VISIBLE    (V_VISIBLE),
    .CNT_W      (COORD_W)
  ) u_vcnt (
    .clk_i     (vga_clk),
    .rst_ni    (reset_n),
    .en_i      (h_wrap),
    .count_o   (vc),
    .wrap_o    (v_wrap),
    .sync_n_o  (v_sync_n),
    .visible_o (v_vis)
  );

  // origin_q is set whenever the counters sit at (0,0): after reset and
  // after a frame wrap, so frame_start needs no wide compare.
  logic   origin_q, origin_d;
  logic   hs_q, hs_d, vs_q, vs_d, blank_q, blank_d;
  logic   ls_q, ls_d, fs_q, fs_d;
  coord_t x_q, x_d, y_q, y_d;
  fcnt_t  fc_q, fc_d;

  // Next-state decode: capture the current position on enabled cycles,
  // hold otherwise with the single-cycle pulses forced low.
  always_comb begin
    origin_d = origin_q;
    hs_d     = hs_q;
    vs_d     = vs_q;
    blank_d  = blank_q;
    x_d      = x_q;
    y_d      = y_q;
    fc_d     = fc_q;
    ls_d     = 1'b0;
    fs_d     = 1'b0;
    if (pix_en) begin
      origin_d = v_wrap;
      hs_d     = h_sync_n;
      vs_d     = v_sync_n;
      blank_d  = h_vis && v_vis;
      x_d      = hc;
      y_d      = vc;
      ls_d     = (hc == '0);
      fs_d     = origin_q;
      if (origin_q) fc_d = fc_q + FCNT_W'(1);
    end
  end

  // Output registers; reset abandons any frame in progress with syncs idle.
  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      origin_q <= 1'b1;
      hs_q     <= 1'b1;
      vs_q     <= 1'b1;
      blank_q  <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      ls_q     <= 1'b0;
      fs_q     <= 1'b0;
      fc_q     <= '0;
    end else begin
      origin_q <= origin_d;
      hs_q     <= hs_d;
      vs_q     <= vs_d;
      blank_q  <= blank_d;
      x_q      <= x_d;
      y_q      <= y_d;
      ls_q     <= ls_d;
      fs_q     <= fs_d;
      fc_q     <= fc_d;
    end
  end

  assign hs          = hs_q;
  assign vs          = vs_q;
  assign blank       = blank_q;
  assign DrawX       = x_q;
  assign DrawY       = y_q;
  assign line_start  = ls_q;
  assign frame_start = fs_q;
  assign frame_count = fc_q;

endmodule
